// File: rtl/ic_to_p_if.sv
// Bundles the load-side matrices and the dense-vector output stream of ic_to_p.
// The slave modport is the decompressor; the master modport is the driver/consumer.
interface ic_to_p_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned s          = 3,
    parameter int unsigned kh         = 3,
    parameter int unsigned kw         = 3
);
    logic                             load;
    logic [s*kh*kw*DATA_WIDTH-1:0]    c_flat;
    logic [s*kh*kw*DATA_WIDTH-1:0]    i_flat;
    logic [kh*kw*DATA_WIDTH-1:0]      out_data;
    logic [DATA_WIDTH-1:0]            out_k;
    logic                             out_valid;
    logic                             out_ready;
    logic                             busy;
    logic                             done;
    logic                             fmt_err;

    modport master (
        output load, c_flat, i_flat, out_ready,
        input  out_data, out_k, out_valid, busy, done, fmt_err
    );

    modport slave (
        input  load, c_flat, i_flat, out_ready,
        output out_data, out_k, out_valid, busy, done, fmt_err
    );
endinterface

// File: rtl/ic_to_p.sv
// Decompresses one C/I matrix pair into k dense vectors (one per k_index 1..k),
// streamed over a valid/ready handshake with all outputs registered.
module ic_to_p #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned s          = 3,
    parameter int unsigned kh         = 3,
    parameter int unsigned kw         = 3,
    parameter int unsigned k          = 10
) (
    input logic        clk,
    input logic        rst_b,
    ic_to_p_if.slave   bus
);
    localparam int Dw      = int'(DATA_WIDTH);
    localparam int Slots   = int'(s);
    localparam int Lanes   = int'(kh * kw);
    localparam int Entries = Slots * Lanes;
    localparam int MatW    = Entries * Dw;
    localparam int VecW    = Lanes * Dw;

    typedef logic [Dw-1:0] word_t;
    localparam word_t KMax = word_t'(k);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q;
    logic [MatW-1:0] c_q;
    logic [MatW-1:0] i_q;

    // Descending slot scan so the lowest matching slot is the one left standing.
    function automatic logic [VecW-1:0] decode(input logic [MatW-1:0] c,
                                               input logic [MatW-1:0] i,
                                               input word_t j);
        logic [VecW-1:0] v;
        v = '0;
        for (int ln = 0; ln < Lanes; ln++) begin
            for (int sl = Slots - 1; sl >= 0; sl--) begin
                if (j != '0 && i[(sl*Lanes+ln)*Dw +: Dw] == j) begin
                    v[ln*Dw +: Dw] = c[(sl*Lanes+ln)*Dw +: Dw];
                end
            end
        end
        return v;
    endfunction

    function automatic logic fmt_check(input logic [MatW-1:0] i);
        logic  err;
        logic  seen_zero;
        word_t prev;
        word_t idx;
        err = 1'b0;
        for (int ln = 0; ln < Lanes; ln++) begin
            seen_zero = 1'b0;
            prev      = '0;
            for (int sl = 0; sl < Slots; sl++) begin
                idx = i[(sl*Lanes+ln)*Dw +: Dw];
                if (idx == '0) begin
                    seen_zero = 1'b1;
                end else begin
                    if (idx > KMax) err = 1'b1;
                    if (seen_zero || (prev != '0 && idx <= prev)) err = 1'b1;
                    prev = idx;
                end
            end
        end
        return err;
    endfunction

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q       <= StIdle;
            c_q           <= '0;
            i_q           <= '0;
            bus.out_data  <= '0;
            bus.out_k     <= '0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.fmt_err   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    bus.done <= 1'b0;
                    if (bus.load) begin
                        c_q           <= bus.c_flat;
                        i_q           <= bus.i_flat;
                        bus.fmt_err   <= fmt_check(bus.i_flat);
                        bus.out_data  <= decode(bus.c_flat, bus.i_flat, word_t'(1));
                        bus.out_k     <= word_t'(1);
                        bus.out_valid <= 1'b1;
                        bus.busy      <= 1'b1;
                        state_q       <= StRun;
                    end
                end
                StRun: begin
                    if (bus.out_valid && bus.out_ready) begin
                        if (bus.out_k == KMax) begin
                            bus.out_data  <= '0;
                            bus.out_k     <= '0;
                            bus.out_valid <= 1'b0;
                            bus.busy      <= 1'b0;
                            bus.done      <= 1'b1;
                            state_q       <= StDone;
                        end else begin
                            bus.out_k    <= bus.out_k + word_t'(1);
                            bus.out_data <= decode(c_q, i_q, bus.out_k + word_t'(1));
                        end
                    end
                end
                StDone: begin
                    bus.done <= 1'b0;
                    state_q  <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ic_to_p.sv
// Scoreboard bench for ic_to_p: loads push expected beats, a negedge monitor pops and compares.
module tb_ic_to_p;
    localparam int DW = 8;
    localparam int S  = 3;
    localparam int KH = 3;
    localparam int KW = 3;
    localparam int K  = 10;
    localparam int L  = KH * KW;
    localparam int N  = S * L;

    typedef struct packed {
        logic [DW-1:0]   kk;
        logic [L*DW-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    ic_to_p_if #(.DATA_WIDTH(DW), .s(S), .kh(KH), .kw(KW)) bus ();

    ic_to_p #(.DATA_WIDTH(DW), .s(S), .kh(KH), .kw(KW), .k(K)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    beat_t         exp_q[$];
    beat_t         mon_e;
    int            checks = 0;
    int            passes = 0;
    int            beats  = 0;
    logic [DW-1:0] cm[N];
    logic [DW-1:0] im[N];

    always @(negedge clk) begin
        if (rst_b && bus.out_valid && bus.out_ready) begin
            beats++;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL beat_unexpected: got k=%0d data=%h, required no beat",
                         bus.out_k, bus.out_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.out_k, bus.out_data} !== mon_e)
                    $display("FAIL beat: got k=%0d data=%h, required k=%0d data=%h",
                             bus.out_k, bus.out_data, mon_e.kk, mon_e.data);
                else passes++;
            end
        end
    end

    // Reference decode: first slot in ascending order whose index equals j.
    function automatic logic [L*DW-1:0] model(input int j);
        logic [L*DW-1:0] r;
        logic            found;
        r = '0;
        for (int ln = 0; ln < L; ln++) begin
            found = 1'b0;
            for (int sl = 0; sl < S; sl++) begin
                if (!found && int'(im[sl*L+ln]) == j) begin
                    r[ln*DW +: DW] = cm[sl*L+ln];
                    found = 1'b1;
                end
            end
        end
        return r;
    endfunction

    task automatic clear_mats();
        for (int n = 0; n < N; n++) begin
            cm[n] = 8'($urandom_range(1, 255));
            im[n] = '0;
        end
    endtask

    task automatic set_sparse();
        clear_mats();
        im[0] = 8'd1;  cm[0] = 8'd5;
        im[L] = 8'd4;  cm[L] = 8'd7;
        cm[2*L] = 8'h33;
        im[8] = 8'd10; cm[8] = 8'd9;
    endtask

    task automatic pack();
        for (int n = 0; n < N; n++) begin
            bus.c_flat[n*DW +: DW] = cm[n];
            bus.i_flat[n*DW +: DW] = im[n];
        end
    endtask

    // Called at posedge+1 while idle; returns at posedge+1 after the load edge.
    task automatic do_load();
        beat_t b;
        pack();
        for (int j = 1; j <= K; j++) begin
            b.kk   = DW'(j);
            b.data = model(j);
            exp_q.push_back(b);
        end
        bus.load = 1'b1;
        @(posedge clk);
        #1 bus.load = 1'b0;
    endtask

    task automatic wait_done(output bit seen, output int cyc);
        seen = 1'b0;
        cyc  = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            cyc = c;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_k(input int kv, output bit found);
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (int'(bus.out_k) == kv) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        bus.load = 1'b0; bus.out_ready = 1'b1; bus.c_flat = '0; bus.i_flat = '0;
        #1 rst_b = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_valid: got %b, required 0", bus.out_valid); else passes++;
        checks++; if (bus.out_k !== '0) $display("FAIL rst_k: got %0d, required 0", bus.out_k); else passes++;
        checks++; if (bus.out_data !== '0) $display("FAIL rst_data: got %h, required 0", bus.out_data); else passes++;
        checks++; if ({bus.busy, bus.done, bus.fmt_err} !== 3'b000)
            $display("FAIL rst_flags: got %b, required 000", {bus.busy, bus.done, bus.fmt_err}); else passes++;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_all_zero();
        bit seen;
        int cyc;
        clear_mats();
        beats = 0;
        do_load();
        wait_done(seen, cyc);
        checks++; if (!seen) $display("FAIL zero_done: got no done, required done"); else passes++;
        checks++; if (cyc != K + 1) $display("FAIL zero_done_cycle: got %0d, required %0d", cyc, K + 1); else passes++;
        checks++; if (beats != K) $display("FAIL zero_beats: got %0d, required %0d", beats, K); else passes++;
        checks++; if ({bus.out_valid, bus.busy, bus.fmt_err} !== 3'b000)
            $display("FAIL zero_flags: got %b, required 000", {bus.out_valid, bus.busy, bus.fmt_err}); else passes++;
        checks++; if (bus.out_k !== '0 || bus.out_data !== '0)
            $display("FAIL done_outputs: got k=%0d data=%h, required 0", bus.out_k, bus.out_data); else passes++;
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) $display("FAIL done_width: got %b, required 0", bus.done); else passes++;
        checks++; if (exp_q.size() != 0) $display("FAIL zero_left: got %0d, required 0", exp_q.size()); else passes++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fmt_err();
        bit seen;
        int cyc;
        for (int v = 0; v < 3; v++) begin
            clear_mats();
            case (v)
                0: begin im[2] = 8'd3; im[L+2] = 8'd2; im[3] = 8'd11; end
                1: begin im[L+5] = 8'd2; end
                default: begin im[1] = 8'd2; im[L+1] = 8'd2; end
            endcase
            do_load();
            @(negedge clk);
            checks++; if (bus.fmt_err !== 1'b1) $display("FAIL fmt_err_%0d: got %b, required 1", v, bus.fmt_err); else passes++;
            wait_done(seen, cyc);
            checks++; if (!seen || exp_q.size() != 0)
                $display("FAIL fmt_replay_%0d: got done=%b left=%0d, required done=1 left=0", v, seen, exp_q.size()); else passes++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_sparse();
        bit seen;
        int cyc;
        set_sparse();
        do_load();
        @(negedge clk);
        checks++; if (bus.fmt_err !== 1'b0) $display("FAIL sparse_fmt: got %b, required 0", bus.fmt_err); else passes++;
        checks++; if (bus.out_data[7:0] !== 8'd5) $display("FAIL sparse_k1_lane0: got %0d, required 5", bus.out_data[7:0]); else passes++;
        wait_done(seen, cyc);
        checks++; if (!seen || exp_q.size() != 0)
            $display("FAIL sparse_replay: got done=%b left=%0d, required done=1 left=0", seen, exp_q.size()); else passes++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        bit seen;
        bit found;
        int cyc;
        logic [L*DW-1:0] want;
        set_sparse();
        want = model(4);
        do_load();
        wait_k(4, found);
        checks++; if (!found) $display("FAIL bp_reach_k4: got k=%0d, required 4", bus.out_k); else passes++;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b1 || bus.out_k !== 8'd4 || bus.out_data !== want)
                $display("FAIL bp_stall_%0d: got v=%b k=%0d data=%h, required v=1 k=4 data=%h",
                         c, bus.out_valid, bus.out_k, bus.out_data, want); else passes++;
            @(posedge clk);
        end
        #1 bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.out_k !== 8'd5) $display("FAIL bp_resume: got %0d, required 5", bus.out_k); else passes++;
        wait_done(seen, cyc);
        checks++; if (!seen || exp_q.size() != 0)
            $display("FAIL bp_replay: got done=%b left=%0d, required done=1 left=0", seen, exp_q.size()); else passes++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_in_run();
        bit seen;
        bit found;
        int cyc;
        set_sparse();
        do_load();
        wait_k(5, found);
        for (int n = 0; n < N; n++) begin
            cm[n] = 8'($urandom_range(1, 255));
            im[n] = (n < L) ? 8'd5 : 8'd0;
        end
        pack();
        bus.load = 1'b1;
        @(posedge clk);
        #1 bus.load = 1'b0;
        checks++; if (!found || bus.out_k !== 8'd6 || bus.busy !== 1'b1)
            $display("FAIL run_load_k: got k=%0d busy=%b, required k=6 busy=1", bus.out_k, bus.busy); else passes++;
        wait_done(seen, cyc);
        checks++; if (!seen || exp_q.size() != 0)
            $display("FAIL run_load_replay: got done=%b left=%0d, required done=1 left=0", seen, exp_q.size()); else passes++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        bit seen;
        bit found;
        bit any_done;
        int cyc;
        clear_mats();
        for (int ln = 0; ln < L; ln++) im[ln] = 8'(ln + 1);
        im[L] = 8'd10;
        do_load();
        wait_k(6, found);
        #2 rst_b = 1'b0;
        #1;
        checks++; if (!found || bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL mid_rst_flags: got v=%b busy=%b, required 0 0", bus.out_valid, bus.busy); else passes++;
        checks++; if (bus.out_k !== '0 || bus.out_data !== '0)
            $display("FAIL mid_rst_outputs: got k=%0d data=%h, required 0", bus.out_k, bus.out_data); else passes++;
        exp_q.delete();
        @(posedge clk);
        #1 rst_b = 1'b1;
        any_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done === 1'b1) any_done = 1'b1;
        end
        checks++; if (any_done) $display("FAIL mid_rst_no_done: got done pulse, required none"); else passes++;
        @(posedge clk);
        #1;
        do_load();
        @(negedge clk);
        checks++; if (bus.out_k !== 8'd1) $display("FAIL mid_rst_restart: got %0d, required 1", bus.out_k); else passes++;
        wait_done(seen, cyc);
        checks++; if (!seen || exp_q.size() != 0)
            $display("FAIL mid_rst_replay: got done=%b left=%0d, required done=1 left=0", seen, exp_q.size()); else passes++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_fmt_err();
        test_sparse();
        test_backpressure();
        test_load_in_run();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
